// File: rtl/pipe_ctrl_unit.sv
// Two-stage (ID -> EX) control unit: decodes the instruction held in ID,
// registers the control word into EX, and generates PC redirect, flush and
// load-use stall handling around the pipeline registers.
module pipe_ctrl_unit #(
  parameter int MEM_LANES = 4,
  parameter int REG_AW    = 5,
  parameter int HAZARD_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [31:0]          instr,
  output logic                 instr_ready,
  input  logic                 alu_zero,
  output logic                 ex_valid,
  output logic [3:0]           alu_control,
  output logic                 alu_mux_select,
  output logic                 file_wren,
  output logic [REG_AW-1:0]    wr_addr,
  output logic [MEM_LANES-1:0] data_mem_wren,
  output logic                 mem_rden,
  output logic [2:0]           pc_control,
  output logic                 flush
);

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_JMP  = 3'd1;
  localparam logic [2:0] BR_JR   = 3'd2;
  localparam logic [2:0] BR_BEQ  = 3'd3;
  localparam logic [2:0] BR_BNE  = 3'd4;
  localparam int HALF_LANES = (MEM_LANES < 2) ? MEM_LANES : 2;

  logic        run;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [2:0]  ex_br;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic        unused_bits;

  logic [3:0]           d_alu;
  logic                 d_mux;
  logic                 d_wren;
  logic [REG_AW-1:0]    d_waddr;
  logic [MEM_LANES-1:0] d_mem;
  logic [MEM_LANES-1:0] sh_mask;
  logic                 d_rden;
  logic [2:0]           d_br;
  logic                 reads_rt;
  logic                 hazard;
  logic                 stall;

  assign op          = id_instr[31:26];
  assign rs          = id_instr[25:21];
  assign rt          = id_instr[20:16];
  assign rd          = id_instr[15:11];
  assign funct       = id_instr[5:0];
  assign unused_bits = ^id_instr[10:6];

  // Decode the ID instruction into the control word that EX will carry.
  always_comb begin
    d_alu   = 4'b1111;
    d_mux   = !(op == 6'h00 || op == 6'h02 || op == 6'h03);
    d_wren  = 1'b0;
    d_waddr = '0;
    d_mem   = '0;
    d_rden  = (op == 6'h23);
    d_br    = BR_NONE;
    for (int i = 0; i < MEM_LANES; i++) sh_mask[i] = (i < HALF_LANES);

    if (op == 6'h00) begin
      case (funct)
        6'h24: d_alu = 4'b0000;
        6'h25: d_alu = 4'b0001;
        6'h21: d_alu = 4'b0010;
        6'h26: d_alu = 4'b0011;
        6'h27: d_alu = 4'b0100;
        6'h22: d_alu = 4'b0110;
        6'h2A: d_alu = 4'b0111;
        6'h00: d_alu = 4'b1000;
        6'h02: d_alu = 4'b1001;
        6'h20: d_alu = 4'b1011;
        default: d_alu = 4'b1111;
      endcase
    end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
      d_alu = 4'b1011;
    end else if (op == 6'h04 || op == 6'h05) begin
      d_alu = 4'b1100;
    end

    if (op == 6'h00 && funct != 6'h08) begin
      d_wren  = 1'b1;
      d_waddr = REG_AW'(rd);
    end else if (op == 6'h08 || op == 6'h23) begin
      d_wren  = 1'b1;
      d_waddr = REG_AW'(rt);
    end else if (op == 6'h03) begin
      d_wren  = 1'b1;
      d_waddr = '1;
    end
    // Register 0 is hardwired; never report a write to it.
    if (d_waddr == '0) d_wren = 1'b0;

    case (op)
      6'h2B:   d_mem = '1;
      6'h29:   d_mem = sh_mask;
      6'h28:   d_mem = MEM_LANES'(1);
      default: d_mem = '0;
    endcase

    if (op == 6'h02 || op == 6'h03)         d_br = BR_JMP;
    else if (op == 6'h00 && funct == 6'h08) d_br = BR_JR;
    else if (op == 6'h04)                   d_br = BR_BEQ;
    else if (op == 6'h05)                   d_br = BR_BNE;
  end

  // Resolve PC command from the EX control word and the live ALU zero flag.
  always_comb begin
    pc_control = 3'b000;
    if (ex_valid) begin
      case (ex_br)
        BR_JMP:  pc_control = 3'b001;
        BR_JR:   pc_control = 3'b010;
        BR_BEQ:  pc_control = alu_zero ? 3'b011 : 3'b000;
        BR_BNE:  pc_control = alu_zero ? 3'b000 : 3'b100;
        default: pc_control = 3'b000;
      endcase
    end
  end

  // mem_rden is only ever set for a valid load, so it doubles as "EX holds lw".
  assign reads_rt = (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B);
  assign hazard   = (HAZARD_EN != 0) && id_valid && mem_rden && (wr_addr != '0) &&
                    ((REG_AW'(rs) == wr_addr) || (reads_rt && REG_AW'(rt) == wr_addr));
  assign flush       = (pc_control != 3'b000);
  assign stall       = hazard && !flush;
  assign instr_ready = run && !flush && !stall;

  // ID stage: accept, hold on stall, or drop on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      id_valid <= 1'b0;
      id_instr <= '0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        id_valid <= 1'b0;
      end else if (!stall) begin
        id_valid <= instr_valid && instr_ready;
        id_instr <= instr;
      end
    end
  end

  // EX stage: load the decoded word, or a bubble on stall/flush/empty ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      alu_control    <= 4'b1111;
      alu_mux_select <= 1'b0;
      file_wren      <= 1'b0;
      wr_addr        <= '0;
      data_mem_wren  <= '0;
      mem_rden       <= 1'b0;
      ex_br          <= BR_NONE;
    end else if (flush || stall || !id_valid) begin
      ex_valid       <= 1'b0;
      alu_control    <= 4'b1111;
      alu_mux_select <= 1'b0;
      file_wren      <= 1'b0;
      wr_addr        <= '0;
      data_mem_wren  <= '0;
      mem_rden       <= 1'b0;
      ex_br          <= BR_NONE;
    end else begin
      ex_valid       <= 1'b1;
      alu_control    <= d_alu;
      alu_mux_select <= d_mux;
      file_wren      <= d_wren;
      wr_addr        <= d_waddr;
      data_mem_wren  <= d_mem;
      mem_rden       <= d_rden;
      ex_br          <= d_br;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: default 4-lane instance plus an 8-lane
// instance sharing the same stimulus.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        alu_zero;

  logic       instr_ready, ex_valid, alu_mux_select, file_wren, mem_rden, flush;
  logic [3:0] alu_control;
  logic [4:0] wr_addr;
  logic [3:0] data_mem_wren;
  logic [2:0] pc_control;

  logic       x_ready, x_ex_valid, x_mux, x_wren, x_rden, x_flush;
  logic [3:0] x_alu;
  logic [4:0] x_waddr;
  logic [7:0] x_mem;
  logic [2:0] x_pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_zero(alu_zero), .ex_valid(ex_valid),
    .alu_control(alu_control), .alu_mux_select(alu_mux_select),
    .file_wren(file_wren), .wr_addr(wr_addr), .data_mem_wren(data_mem_wren),
    .mem_rden(mem_rden), .pc_control(pc_control), .flush(flush)
  );

  pipe_ctrl_unit #(.MEM_LANES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(x_ready), .alu_zero(alu_zero), .ex_valid(x_ex_valid),
    .alu_control(x_alu), .alu_mux_select(x_mux),
    .file_wren(x_wren), .wr_addr(x_waddr), .data_mem_wren(x_mem),
    .mem_rden(x_rden), .pc_control(x_pc), .flush(x_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic feed(input logic v, input logic [31:0] i);
    instr_valid = v;
    instr       = i;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s,
                                        input logic [4:0] t);
    return {o, s, t, 16'h0010};
  endfunction

  logic [5:0] fn_tab  [10] = '{6'h24, 6'h25, 6'h21, 6'h26, 6'h27, 6'h22, 6'h2A, 6'h00, 6'h02, 6'h20};
  logic [3:0] alu_tab [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                               4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1011};

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; alu_zero = 1'b0;
    #12;
    chk("rst_ready", instr_ready, 0);
    chk("rst_exv",   ex_valid, 0);
    chk("rst_alu",   alu_control, 4'b1111);
    chk("rst_pc",    pc_control, 0);
    chk("rst_flush", flush, 0);
    chk("rst_wren",  file_wren, 0);
    chk("rst_mem",   data_mem_wren, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("ready_pre_edge", instr_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_edge", instr_ready, 1);

    // add r3 = r1 + r2
    feed(1, rtype(1, 2, 3, 6'h20));
    chk("add_in_id_exv", ex_valid, 0);
    feed(0, 0);
    chk("add_exv",  ex_valid, 1);
    chk("add_alu",  alu_control, 4'b1011);
    chk("add_wren", file_wren, 1);
    chk("add_wa",   wr_addr, 3);
    chk("add_mux",  alu_mux_select, 0);
    chk("add_rden", mem_rden, 0);
    feed(0, 0);
    chk("bubble_exv",  ex_valid, 0);
    chk("bubble_wren", file_wren, 0);

    // lw r5 then add r6 = r5 + r0: one stall cycle
    feed(1, itype(6'h23, 0, 5));
    feed(1, rtype(5, 0, 6, 6'h20));
    chk("lw_rden",  mem_rden, 1);
    chk("lw_wa",    wr_addr, 5);
    chk("lw_mux",   alu_mux_select, 1);
    chk("lw_alu",   alu_control, 4'b1011);
    chk("stall_ready", instr_ready, 0);
    feed(0, 0);
    chk("stall_bubble_exv", ex_valid, 0);
    chk("stall_bubble_rden", mem_rden, 0);
    chk("stall_over_ready", instr_ready, 1);
    feed(0, 0);
    chk("stalled_add_exv", ex_valid, 1);
    chk("stalled_add_wa",  wr_addr, 6);
    feed(0, 0);

    // lw r0 then add reading r0: no stall
    feed(1, itype(6'h23, 0, 0));
    feed(1, rtype(0, 0, 7, 6'h20));
    chk("lw_r0_wren",  file_wren, 0);
    chk("lw_r0_ready", instr_ready, 1);
    feed(0, 0);
    chk("nostall_add_wa", wr_addr, 7);
    feed(0, 0);

    // sw r5 in ID while lw r5 in EX: store reads rt -> stall
    feed(1, itype(6'h23, 0, 5));
    feed(1, itype(6'h2B, 1, 5));
    chk("sw_rt_stall", instr_ready, 0);
    feed(0, 0);
    feed(0, 0);
    chk("sw_mem", data_mem_wren, 4'b1111);
    chk("sw_wren", file_wren, 0);
    feed(0, 0);

    // beq taken, following add must be squashed
    feed(1, itype(6'h04, 1, 2));
    feed(1, rtype(1, 2, 9, 6'h20));
    alu_zero = 1'b1; #1;
    chk("beq_pc",    pc_control, 3'b011);
    chk("beq_flush", flush, 1);
    chk("beq_ready", instr_ready, 0);
    chk("beq_alu",   alu_control, 4'b1100);
    feed(0, 0);
    alu_zero = 1'b0;
    chk("beq_sq1_exv", ex_valid, 0);
    feed(0, 0);
    chk("beq_sq2_exv", ex_valid, 0);

    // bne: not taken with zero=1, taken with zero=0
    feed(1, itype(6'h05, 1, 2));
    feed(0, 0);
    alu_zero = 1'b1; #1;
    chk("bne_nt_pc",    pc_control, 0);
    chk("bne_nt_flush", flush, 0);
    alu_zero = 1'b0; #1;
    chk("bne_t_pc",    pc_control, 3'b100);
    chk("bne_t_flush", flush, 1);
    feed(0, 0);

    // stores: sh and sb on both lane widths
    feed(1, itype(6'h29, 1, 2));
    feed(0, 0);
    chk("sh_mem4", data_mem_wren, 4'b0011);
    chk("sh_mem8", x_mem, 8'b00000011);
    feed(1, itype(6'h28, 1, 2));
    feed(0, 0);
    chk("sb_mem4", data_mem_wren, 4'b0001);
    chk("sb_mem8", x_mem, 8'b00000001);
    feed(1, itype(6'h2B, 1, 2));
    feed(0, 0);
    chk("sw_mem8", x_mem, 8'hFF);

    // addi to r0 suppressed, addi to r9 writes
    feed(1, itype(6'h08, 1, 0));
    feed(1, itype(6'h08, 1, 9));
    chk("addi_r0_wren", file_wren, 0);
    feed(0, 0);
    chk("addi_wren", file_wren, 1);
    chk("addi_wa",   wr_addr, 9);
    chk("addi_alu",  alu_control, 4'b1011);

    // jr
    feed(1, rtype(31, 0, 0, 6'h08));
    feed(0, 0);
    chk("jr_pc",   pc_control, 3'b010);
    chk("jr_wren", file_wren, 0);
    chk("jr_alu",  alu_control, 4'b1111);
    feed(0, 0);

    // R-type ALU encodings
    for (int k = 0; k < 10; k++) begin
      feed(1, rtype(1, 2, 4, fn_tab[k]));
      feed(0, 0);
      chk($sformatf("rtype_alu_%0h", fn_tab[k]), alu_control, alu_tab[k]);
    end

    // jal in EX, then asynchronous reset mid-cycle
    feed(1, itype(6'h03, 0, 0));
    feed(0, 0);
    chk("jal_pc",   pc_control, 3'b001);
    chk("jal_wren", file_wren, 1);
    chk("jal_wa",   wr_addr, 5'd31);
    chk("jal_alu",  alu_control, 4'b1111);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc",    pc_control, 0);
    chk("async_alu",   alu_control, 4'b1111);
    chk("async_wren",  file_wren, 0);
    chk("async_exv",   ex_valid, 0);
    chk("async_flush", flush, 0);
    chk("async_ready", instr_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rerun_ready", instr_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter MEM_LANES, default 4: number of byte lanes in data memory, so data_mem_wren is MEM_LANES bits wide; legal values 1, 2, 4 or 8.
REQ-002 Parameter REG_AW, default 5: register-file address width.
REQ-003 Parameter HAZARD_EN, default 1: 1 enables load-use stall detection; 0 disables it.
REQ-004 One clock; reset is asynchronous and active-low (clk, rst_n).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 instr_valid  in  1  instr carries a fetched instruction.
REQ-008 instr  in  32  instruction; op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
REQ-009 instr_ready  out  1  decode accepts instr this cycle.
REQ-010 alu_zero  in  1  zero flag from the ALU for the instruction in EX.
REQ-011 ex_valid  out  1  EX-stage control outputs are live.
REQ-012 alu_control  out  4  ALU operation for EX.
REQ-013 alu_mux_select  out  1  1 = immediate operand.
REQ-014 file_wren  out  1  register-file write enable.
REQ-015 wr_addr  out  REG_AW  destination register.
REQ-016 data_mem_wren  out  MEM_LANES  per-lane store enable.
REQ-017 mem_rden  out  1  load in EX.
REQ-018 pc_control  out  3  PC command.
REQ-019 flush  out  1  PC is redirected; fetch shall discard its in-flight instruction.

Function
REQ-020 Two registered stages, ID then EX; an accepted instruction drives the EX outputs exactly 1 cycle after it is accepted.
REQ-021 ID accepts an instruction when instr_valid=1 and instr_ready=1.
REQ-022 alu_control encoding, first match wins:
- R-type (op=0) by funct: 24=0000, 25=0001, 21=0010, 26=0011, 27=0100, 22=0110, 2A=0111, 00=1000, 02=1001, 20=1011.
- op 08, 23 or 2B = 1011.
- op 04 or 05 = 1100.
- all others = 1111.
REQ-023 alu_mux_select=1 for every op other than 00, 02 and 03.
REQ-024 file_wren=1 and wr_addr as follows:
- R-type except jr (funct 08): wr_addr=rd.
- op 08 and op 23: wr_addr=rt.
- jal: wr_addr=all ones.
- otherwise: file_wren=0.
REQ-025 data_mem_wren:
- op 2B (sw): all lanes.
- op 29 (sh): lower min(2,MEM_LANES) lanes.
- op 28 (sb): lane 0 only.
- otherwise: 0.
REQ-026 mem_rden=1 only for op 23.
REQ-027 pc_control is valid in EX only:
- j or jal: 001.
- jr: 010.
- beq with alu_zero=1: 011.
- bne with alu_zero=0: 100.
- otherwise: 000.
REQ-028 flush=1 in any EX cycle with pc_control≠000; in that same cycle ID is invalidated and instr_ready=0.
REQ-029 Load-use stall (HAZARD_EN=1): when EX holds op 23 with rt≠0, and the ID instruction reads that register (rs, or rt for R-type, 04, 05 and 2B):
- ID holds its instruction.
- instr_ready=0.
- a bubble enters EX.
The stall lasts exactly one cycle.
REQ-030 A bubble or an invalid slot forces all EX write enables, mem_rden and flush to 0, and pc_control to 000.
REQ-031 When flush and a stall condition occur in the same cycle, flush wins and the stall is cancelled.
REQ-032 A decoded write to register 0 has file_wren forced to 0.
REQ-033 With instr_valid=0, ID loads a bubble.

Reset
REQ-034 While rst_n=0:
- both stages are invalid.
- all outputs are 0, except alu_control=1111.
- instr_ready=0.
REQ-035 Reset asserted mid-operation discards in-flight instructions immediately, asynchronously.
REQ-036 instr_ready=1 from the first clock edge after rst_n deasserts.

Verification
REQ-037 Feed R-type add (funct 20, rd=3) -> next cycle: ex_valid=1, alu_control=1011, file_wren=1, wr_addr=3.
REQ-038 Feed lw r5 followed by add using rs=5 -> instr_ready=0 for one cycle, then add reaches EX one cycle later than unstalled.
REQ-039 Feed beq with alu_zero=1 in EX -> pc_control=011 and flush=1; the following instruction never reaches EX with ex_valid=1.
REQ-040 Feed bne with alu_zero=1 -> pc_control=000 and flush=0.
REQ-041 Feed sh with MEM_LANES=4 -> data_mem_wren=0011; sb with MEM_LANES=8 -> 00000001.
REQ-042 Assert rst_n=0 while a jal is in EX -> outputs clear without waiting for a clock edge; pc_control=000, alu_control=1111.
